// File: rtl/uart_pkg.sv
// Shared UART definitions for the Pong host link.
// Holds the transmitter FSM state encoding and the default bit period
// (25 MHz / 115200), which the UART receiver also uses.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 217;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/sync_byte_fifo.sv
// Synchronous byte FIFO with first-word-fall-through read data.
// Ports:
//   clk, rst       - clock, synchronous active-high reset (empties the FIFO)
//   wr_en, wr_data - write request; ignored when full
//   full           - count == DEPTH
//   rd_en, rd_data - pop request; rd_data is the head, valid whenever !empty
//   empty          - count == 0
//   count          - number of stored bytes
// A write is judged against the count before any same-cycle pop, so a write
// at full is dropped even if a pop frees a slot in the same cycle.
module sync_byte_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  output logic                     full,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          wr_ok;
  logic          rd_ok;

  always_comb begin
    full    = (cnt == CW'(DEPTH));
    empty   = (cnt == '0);
    wr_ok   = wr_en && !full;
    rd_ok   = rd_en && !empty;
    rd_data = mem[rd_ptr];
    count   = cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(wr_ok) - CW'(rd_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !rst) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter for score/status reporting to the host.
// Ports:
//   i_Clk, i_Rst   - clock, synchronous active-high reset
//   i_TX_DV        - write strobe; i_TX_Byte is queued on each high cycle
//   i_TX_Byte      - byte to queue
//   o_TX_Ready     - FIFO not full
//   o_Overflow     - one-cycle pulse the cycle after a write was dropped
//   o_FIFO_Count   - bytes queued, excluding the byte on the wire
//   o_TX_Serial    - serial line, idle high, LSB first
//   o_TX_Active    - high while start..stop is on the wire
//   o_TX_Done      - high for the final stop-bit cycle of each frame
// Frames are sent back-to-back with no idle gap while bytes are queued.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                          i_Clk,
  input  logic                          i_Rst,
  input  logic                          i_TX_DV,
  input  logic [7:0]                    i_TX_Byte,
  output logic                          o_TX_Ready,
  output logic                          o_Overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_FIFO_Count,
  output logic                          o_TX_Serial,
  output logic                          o_TX_Active,
  output logic                          o_TX_Done
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CLK = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t        state_q, state_d;
  logic [CNT_W-1:0] clk_q, clk_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             serial_q, serial_d;
  logic             done_q, done_d;
  logic             active_q;
  logic             ovf_q;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_head;

  sync_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (i_Clk),
    .rst     (i_Rst),
    .wr_en   (i_TX_DV),
    .wr_data (i_TX_Byte),
    .full    (fifo_full),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .empty   (fifo_empty),
    .count   (o_FIFO_Count)
  );

  // The serial line is computed from the next state so that it is a flop
  // output and changes on the same edge as the state transition.
  always_comb begin
    state_d  = state_q;
    clk_d    = clk_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    serial_d = 1'b1;
    pop      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          shift_d  = fifo_head;
          bit_d    = '0;
          clk_d    = '0;
          state_d  = START;
          serial_d = 1'b0;
        end
      end
      START: begin
        if (clk_q == LAST_CLK) begin
          clk_d    = '0;
          state_d  = DATA;
          serial_d = shift_q[0];
        end else begin
          clk_d    = clk_q + 1'b1;
          serial_d = 1'b0;
        end
      end
      DATA: begin
        if (clk_q == LAST_CLK) begin
          clk_d = '0;
          if (bit_q == 3'd7) begin
            state_d  = STOP;
            serial_d = 1'b1;
          end else begin
            bit_d    = bit_q + 3'd1;
            serial_d = shift_q[bit_q + 3'd1];
          end
        end else begin
          clk_d    = clk_q + 1'b1;
          serial_d = shift_q[bit_q];
        end
      end
      STOP: begin
        if (clk_q == LAST_CLK) begin
          clk_d = '0;
          if (!fifo_empty) begin
            pop      = 1'b1;
            shift_d  = fifo_head;
            bit_d    = '0;
            state_d  = START;
            serial_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          clk_d = clk_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered Done must coincide with the final stop cycle itself.
    done_d = (state_d == STOP) && (clk_d == LAST_CLK);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q  <= IDLE;
      clk_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      serial_q <= 1'b1;
      done_q   <= 1'b0;
      active_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      clk_q    <= clk_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
      done_q   <= done_d;
      active_q <= (state_d != IDLE);
      ovf_q    <= i_TX_DV && fifo_full;
    end
  end

  always_comb begin
    o_TX_Ready  = !fifo_full;
    o_Overflow  = ovf_q;
    o_TX_Serial = serial_q;
    o_TX_Active = active_q;
    o_TX_Done   = done_q;
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered with CLKS_PER_BIT=4, FIFO_DEPTH=16.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_uart_tx_buffered;

  logic       clk;
  logic       rst;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_ready;
  logic       overflow;
  logic [4:0] fifo_count;
  logic       tx_serial;
  logic       tx_active;
  logic       tx_done;

  int checks = 0;
  int errors = 0;

  uart_tx_buffered #(
    .CLKS_PER_BIT (4),
    .FIFO_DEPTH   (16)
  ) dut (
    .i_Clk        (clk),
    .i_Rst        (rst),
    .i_TX_DV      (tx_dv),
    .i_TX_Byte    (tx_byte),
    .o_TX_Ready   (tx_ready),
    .o_Overflow   (overflow),
    .o_FIFO_Count (fifo_count),
    .o_TX_Serial  (tx_serial),
    .o_TX_Active  (tx_active),
    .o_TX_Done    (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks frame cycles first_k..40 of the frame carrying b (cycle 1 is the
  // first start-bit cycle). The FIFO count is checked at cycle first_k.
  task automatic frame(input logic [7:0] b, input int first_k,
                       input logic [4:0] cnt_first, input string tag);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int k = first_k; k <= 40; k++) begin
      @(negedge clk);
      chk({tag, "_serial"}, 32'(tx_serial), 32'(f[(k - 1) / 4]));
      chk({tag, "_done"},   32'(tx_done),   32'(k == 40));
      chk({tag, "_active"}, 32'(tx_active), 32'd1);
      if (k == first_k) chk({tag, "_count"}, 32'(fifo_count), 32'(cnt_first));
    end
  endtask

  task automatic idle_chk(input string tag);
    @(negedge clk);
    chk({tag, "_idle_serial"}, 32'(tx_serial), 32'd1);
    chk({tag, "_idle_active"}, 32'(tx_active), 32'd0);
    chk({tag, "_idle_done"},   32'(tx_done),   32'd0);
  endtask

  initial begin
    logic [9:0] f41;
    rst     = 1'b1;
    tx_dv   = 1'b0;
    tx_byte = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_serial", 32'(tx_serial), 32'd1);
    chk("rst_active", 32'(tx_active), 32'd0);
    chk("rst_done",   32'(tx_done),   32'd0);
    chk("rst_ovf",    32'(overflow),  32'd0);
    chk("rst_ready",  32'(tx_ready),  32'd1);
    chk("rst_count",  32'(fifo_count), 32'd0);
    rst = 1'b0;

    // Single byte 0xA5: line 0,1,0,1,0,0,1,0,1,1 from the edge after the write.
    @(negedge clk);
    tx_dv = 1'b1; tx_byte = 8'hA5;
    @(negedge clk);
    tx_dv = 1'b0;
    chk("a5_wr_count",  32'(fifo_count), 32'd1);
    chk("a5_wr_serial", 32'(tx_serial),  32'd1);
    chk("a5_wr_active", 32'(tx_active),  32'd0);
    frame(8'hA5, 1, 5'd0, "a5");
    idle_chk("a5");

    // Burst of three gapless frames.
    @(negedge clk);
    tx_dv = 1'b1; tx_byte = 8'h00;
    @(negedge clk);
    chk("burst_c0", 32'(fifo_count), 32'd1);
    chk("burst_s0", 32'(tx_serial),  32'd1);
    tx_byte = 8'hFF;
    @(negedge clk);
    chk("burst_c1", 32'(fifo_count), 32'd1);
    chk("burst_s1", 32'(tx_serial),  32'd0);
    chk("burst_a1", 32'(tx_active),  32'd1);
    tx_byte = 8'h55;
    @(negedge clk);
    chk("burst_c2", 32'(fifo_count), 32'd2);
    chk("burst_s2", 32'(tx_serial),  32'd0);
    tx_dv = 1'b0;
    frame(8'h00, 3, 5'd2, "burst0");
    frame(8'hFF, 1, 5'd1, "burst1");
    frame(8'h55, 1, 5'd0, "burst2");
    idle_chk("burst");

    // Overflow: 18 consecutive writes, the last one dropped.
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i == 17) begin
        chk("ovf_full_count", 32'(fifo_count), 32'd16);
        chk("ovf_full_ready", 32'(tx_ready),   32'd0);
        chk("ovf_pre_pulse",  32'(overflow),   32'd0);
      end
      tx_dv = 1'b1; tx_byte = 8'(8'h10 + i);
    end
    @(negedge clk);
    tx_dv = 1'b0;
    chk("ovf_pulse",       32'(overflow),   32'd1);
    chk("ovf_pulse_count", 32'(fifo_count), 32'd16);
    @(negedge clk);
    chk("ovf_pulse_end",   32'(overflow),   32'd0);
    chk("ovf_ready_hold",  32'(tx_ready),   32'd0);
    frame(8'h10, 19, 5'd16, "ovf_f0");
    chk("ovf_ready_f0end", 32'(tx_ready), 32'd0);
    for (int j = 1; j <= 16; j++) begin
      frame(8'(8'h10 + j), 1, 5'(16 - j), "ovf_fn");
      if (j == 1) chk("ovf_ready_after", 32'(tx_ready), 32'd1);
    end
    idle_chk("ovf");

    // Fill, then write on the STOP->START pop edge: dropped, count 15.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      tx_dv = 1'b1; tx_byte = 8'(8'h40 + i);
    end
    @(negedge clk);
    tx_dv = 1'b0;
    chk("fill_count", 32'(fifo_count), 32'd16);
    frame(8'h40, 17, 5'd16, "fill_f0");
    tx_dv = 1'b1; tx_byte = 8'hEE;
    @(negedge clk);
    tx_dv = 1'b0;
    chk("popfull_ovf",    32'(overflow),   32'd1);
    chk("popfull_count",  32'(fifo_count), 32'd15);
    chk("popfull_serial", 32'(tx_serial),  32'd0);

    // Reset for one cycle during DATA bit 3 of the 0x41 frame (cycles 17..20).
    f41 = {1'b1, 8'h41, 1'b0};
    for (int k = 2; k <= 18; k++) begin
      @(negedge clk);
      chk("f41_serial", 32'(tx_serial), 32'(f41[(k - 1) / 4]));
      if (k == 18) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_serial", 32'(tx_serial),  32'd1);
    chk("mrst_active", 32'(tx_active),  32'd0);
    chk("mrst_count",  32'(fifo_count), 32'd0);
    chk("mrst_done",   32'(tx_done),    32'd0);
    chk("mrst_ready",  32'(tx_ready),   32'd1);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      chk("mrst_q_serial", 32'(tx_serial), 32'd1);
      chk("mrst_q_done",   32'(tx_done),   32'd0);
    end
    @(negedge clk);
    tx_dv = 1'b1; tx_byte = 8'h3C;
    @(negedge clk);
    tx_dv = 1'b0;
    chk("x3c_count", 32'(fifo_count), 32'd1);
    frame(8'h3C, 1, 5'd0, "x3c");
    idle_chk("x3c");

    // Idle hold.
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      chk("hold_serial", 32'(tx_serial), 32'd1);
      chk("hold_done",   32'(tx_done),   32'd0);
      chk("hold_ovf",    32'(overflow),  32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
